// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display controller: register map,
// controller states and the power-up command table.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    // Index of the final power-up word (shutdown, test, decode, scan, intensity,
    // eight digit clears, normal operation).
    localparam logic [3:0] INIT_LAST = 4'd13;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_IDLE      = 3'd4
    } state_e;

    function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] intensity);
        logic [15:0] w;
        case (idx)
            4'd0:    w = {4'h0, REG_SHUTDOWN, 8'h00};
            4'd1:    w = {4'h0, REG_TEST, 8'h00};
            4'd2:    w = {4'h0, REG_DECODE, 8'h00};
            4'd3:    w = {4'h0, REG_SCANLIM, 8'h07};
            4'd4:    w = {4'h0, REG_INTENSITY, 4'h0, intensity};
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12:
                     w = {4'h0, idx - 4'd4, 8'h00};
            4'd13:   w = {4'h0, REG_SHUTDOWN, 8'h01};
            default: w = {4'h0, REG_NOOP, 8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_ctrl.sv
// MAX7219 controller: power-up command sequence, then periodic streaming of
// an 8x8 frame buffer to the serializer through a start/busy handshake.
module max7219_ctrl
    import max7219_pkg::*;
#(
    parameter logic [3:0] INTENSITY      = 4'h8,
    parameter int         REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        tx_start,
    output logic [15:0] tx_data,
    input  logic        tx_busy,
    output logic        init_done,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REFRESH_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic               refresh_q, refresh_d;
    logic               tx_start_q, tx_start_d;
    logic [15:0]        tx_data_q, tx_data_d;
    logic               init_done_q, init_done_d;
    logic               frame_done_q, frame_done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         fb_q [8];
    logic [3:0]         digit_s;
    logic [15:0]        word_s;

    // Frame buffer rows; a write lands on the same edge that may sample the old row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                fb_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            fb_q[wr_addr] <= wr_data;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            idx_q        <= 4'd0;
            refresh_q    <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 16'h0000;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            refresh_q    <= refresh_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
        end
    end

    // Word to send next: power-up table, or digit register row+1 with its pixels.
    always_comb begin
        digit_s = {1'b0, idx_q[2:0]} + REG_DIGIT0;
        if (refresh_q) begin
            word_s = {4'h0, digit_s, fb_q[idx_q[2:0]]};
        end else begin
            word_s = init_word(idx_q, INTENSITY);
        end
    end

    // Next-state logic for the issue / acknowledge / completion handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        refresh_d    = refresh_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = word_s;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (!refresh_q) begin
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        refresh_d   = 1'b1;
                        idx_d       = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                    state_d = ST_ISSUE;
                end else if (idx_q[2:0] == 3'd7) begin
                    frame_done_d = 1'b1;
                    idx_d        = 4'd0;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_IDLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// Directed bench for max7219_ctrl against a busy-stub serializer that raises
// busy the cycle after start and holds it for busy_len cycles.
module tb_max7219_ctrl;

    localparam int B = 20;
    localparam int R = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        tx_start;
    logic [15:0] tx_data;
    logic        tx_busy;
    logic        init_done;
    logic        frame_done;
    logic        hold_busy = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int stub_cnt = 0;

    logic [15:0] words[$];
    int          start_t[$];
    int          fd_t[$];
    int          init_rise[$];
    logic        prev_start = 1'b0;
    logic        prev_init  = 1'b0;

    logic [15:0] exp_init [14] = '{16'h0C00, 16'h0F00, 16'h0900, 16'h0B07, 16'h0A03,
                                   16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                                   16'h0600, 16'h0700, 16'h0800, 16'h0C01};
    logic [7:0]  exp_fb [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};

    max7219_ctrl #(.INTENSITY(4'h3), .REFRESH_CYCLES(R)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) stub_cnt <= 0;
        else if (tx_start) stub_cnt <= B;
        else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    end
    assign tx_busy = (stub_cnt != 0) || hold_busy;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Protocol monitor: log every word and event time, police the handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                check("start_while_busy", {31'd0, tx_busy}, 32'd0);
                check("back_to_back", {31'd0, prev_start}, 32'd0);
                words.push_back(tx_data);
                start_t.push_back(cyc);
            end
            if (frame_done) fd_t.push_back(cyc);
            if (init_done && !prev_init) init_rise.push_back(cyc);
        end
        prev_start = tx_start;
        prev_init  = init_done;
    end

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (words.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_words", {31'd0, words.size() >= n}, 32'd1);
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_t.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_frame_done", {31'd0, fd_t.size() >= n}, 32'd1);
    endtask

    task automatic wait_word_start(input logic [15:0] w, input int budget);
        int k = 0;
        while (!(tx_start === 1'b1 && tx_data === w) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_word_start", {31'd0, k < budget}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] row2);
        logic [15:0] e;
        for (int r = 0; r < 8; r++) begin
            e = {4'h0, 4'(r + 1), (r == 2) ? row2 : exp_fb[r]};
            check(tag, {16'd0, words[base + r]}, {16'd0, e});
        end
    endtask

    initial begin
        int n0;
        int base;
        repeat (10) @(negedge clk);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {16'd0, tx_data}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = exp_fb[i];
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Power-up sequence, B+3 cycles per word.
        wait_words(14, 1000);
        for (int i = 0; i < 14; i++) check("init_word", {16'd0, words[i]}, {16'd0, exp_init[i]});
        check("word_spacing", start_t[1] - start_t[0], B + 3);
        wait_words(15, 200);
        check("init_rise_count", init_rise.size(), 1);
        check("init_rise_time", init_rise[0], start_t[13] + B + 2);

        // First frame with the pattern written during power-up.
        wait_fd(1, 1000);
        check_frame("frame1", 14, 8'h24);
        check("frame1_fd_count", fd_t.size(), 1);
        check("frame1_fd_time", fd_t[0], start_t[21] + B + 2);
        wait_words(23, 200);
        // IDLE spans R cycles, then one ISSUE cycle before the start pulse.
        check("period1", start_t[22] - fd_t[0], R + 1);

        // Write row 2 in the very cycle its word is started.
        wait_word_start(16'h0324, 1000);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        wait_fd(2, 1000);
        check_frame("frame2_old_row", 22, 8'h24);
        wait_words(31, 200);
        check("period2", start_t[30] - fd_t[1], R + 1);
        wait_fd(3, 1000);
        check_frame("frame3_new_row", 30, 8'hFF);

        // Serializer busy for 200 cycles while the controller wants to issue.
        hold_busy = 1'b1;
        n0 = words.size();
        repeat (200) @(negedge clk);
        check("no_start_while_held", words.size(), n0);
        hold_busy = 1'b0;
        wait_fd(4, 1000);
        check("one_pulse_per_word", words.size(), 46);
        check_frame("frame4", 38, 8'hFF);

        // Reset in the middle of the row-4 transfer.
        wait_word_start(16'h0518, 1000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
        check("mid_rst_tx_data", {16'd0, tx_data}, 32'd0);
        base = words.size();
        @(negedge clk);
        rst = 1'b0;
        wait_words(base + 22, 2000);
        for (int i = 0; i < 14; i++) check("reinit_word", {16'd0, words[base + i]}, {16'd0, exp_init[i]});
        for (int r = 0; r < 8; r++) check("fb_cleared", {16'd0, words[base + 14 + r]}, {16'd0, 4'h0, 4'(r + 1), 8'h00});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
